serial_command_decoder: RTL and testbench

- Device-side responder for the host word protocol carried over the RS232 link.
- Takes received bytes from the RS232 receiver (RX/hasRX) and assembles them into 32-bit words, most significant byte first.
- Decodes the escape-prefixed command stream and performs the action:
  - UPLOAD: words are written to memory.
  - DOWNLOAD: memory words are streamed back through the RS232 transmitter.
  - Reset control: drives a hold-in-reset line for the rest of Main.
- Sits inside Main, between the RS232 instance and the memory/CPU reset logic.

---
 rtl/serial_cmd_pkg.sv | 30 +++
 rtl/serial_command_decoder_assembler.sv | 54 +++++
 rtl/serial_command_decoder.sv | 131 +++++++++++++
 tb/tb_serial_command_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmd_pkg.sv
// serial_cmd_pkg: command codes, escape word and decoder state encoding
// shared by the serial command decoder and its testbench.
package serial_cmd_pkg;

    localparam logic [31:0] ESCAPE_WORD  = 32'h0000_0000;
    localparam logic [31:0] CMD_NOP      = 32'd0;
    localparam logic [31:0] CMD_UPLOAD   = 32'd2;
    localparam logic [31:0] CMD_DOWNLOAD = 32'd3;
    localparam logic [31:0] CMD_RST_HIGH = 32'd4;
    localparam logic [31:0] CMD_RST_LOW  = 32'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_UP_START,
        S_UP_END,
        S_UP_DATA,
        S_DN_START,
        S_DN_END,
        S_DN_READ,
        S_DN_WAIT,
        S_DN_SEND
    } decoder_state_t;

    function automatic logic is_known_cmd(input logic [31:0] code);
        return code == CMD_NOP || code == CMD_UPLOAD || code == CMD_DOWNLOAD ||
               code == CMD_RST_HIGH || code == CMD_RST_LOW;
    endfunction

endpackage

// File: rtl/serial_command_decoder_assembler.sv
// byte_word_assembler: packs received bytes MSB-first into 32-bit words and
// discards a partial word on a framing error or after an idle timeout.
module byte_word_assembler #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    count_q, count_d;
    logic [31:0]   word_q, word_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout;

    always_comb begin
        timeout = count_q != 2'd0 && !rx_valid && timer_q == TW'(TIMEOUT_CYCLES - 1);
        word_d  = rx_valid ? {word_q[23:0], rx_data} : word_q;
        count_d = (rx_error || timeout) ? 2'd0 : rx_valid ? count_q + 2'd1 : count_q;
        valid_d = rx_valid && !rx_error && count_q == 2'd3;
        err_d   = rx_error || timeout;
        timer_d = (rx_valid || count_q == 2'd0 || timeout) ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            count_q <= count_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
    assign error      = err_q;

endmodule

// File: rtl/serial_command_decoder.sv
// serial_command_decoder: decodes escape-prefixed host words into memory
// upload/download transfers and CPU reset control.
module serial_command_decoder
    import serial_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_error,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [31:0]           mem_rdata,
    output logic                  force_rst,
    output logic                  busy,
    output logic                  proto_error
);

    decoder_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, end_q, end_d;
    logic [31:0]           data_q, data_d;
    logic [1:0]            idx_q, idx_d;
    logic                  force_q, force_d;
    logic                  skip_q, skip_d;
    logic [31:0]           word;
    logic                  word_valid, asm_error, tx_fire, cmd_bad;
    logic [ADDR_WIDTH-1:0] word_addr, addr_next;

    byte_word_assembler #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .word       (word),
        .word_valid (word_valid),
        .error      (asm_error)
    );

    assign word_addr = {word[ADDR_WIDTH-1:2], 2'b00};
    assign addr_next = addr_q + ADDR_WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            force_q <= 1'b1;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            force_q <= force_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        data_d  = data_q;
        idx_d   = idx_q;
        force_d = force_q;
        skip_d  = 1'b0;
        case (state_q)
            S_IDLE: if (word_valid && word == ESCAPE_WORD) state_d = S_CMD;
            S_CMD: if (word_valid) begin
                state_d = word == CMD_UPLOAD ? S_UP_START : word == CMD_DOWNLOAD ? S_DN_START : S_IDLE;
                force_d = word == CMD_RST_HIGH ? 1'b1 : word == CMD_RST_LOW ? 1'b0 : force_q;
            end
            S_UP_START, S_DN_START: if (word_valid) begin
                addr_d  = word_addr;
                state_d = state_q == S_UP_START ? S_UP_END : S_DN_END;
            end
            // end is exclusive; an empty or inverted range ends the command
            S_UP_END, S_DN_END: if (word_valid) begin
                end_d   = word_addr;
                state_d = word_addr <= addr_q ? S_IDLE : state_q == S_UP_END ? S_UP_DATA : S_DN_READ;
            end
            S_UP_DATA: if (word_valid) begin
                addr_d  = addr_next;
                state_d = addr_next == end_q ? S_IDLE : S_UP_DATA;
            end
            S_DN_READ: state_d = S_DN_WAIT;
            S_DN_WAIT: begin
                data_d  = mem_rdata;
                idx_d   = 2'd3;
                state_d = S_DN_SEND;
            end
            // the transmitter only drops tx_ready a cycle after our strobe
            S_DN_SEND: if (tx_fire) begin
                skip_d = 1'b1;
                idx_d  = idx_q - 2'd1;
                if (idx_q == 2'd0) begin
                    addr_d  = addr_next;
                    state_d = addr_next == end_q ? S_IDLE : S_DN_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_fire     = state_q == S_DN_SEND && tx_ready && !skip_q;
        cmd_bad     = state_q == S_CMD && word_valid && !is_known_cmd(word);
        tx_start    = tx_fire;
        tx_data     = data_q[{idx_q, 3'b000} +: 8];
        mem_addr    = addr_q;
        mem_wdata   = word;
        mem_we      = state_q == S_UP_DATA && word_valid;
        mem_re      = state_q == S_DN_READ;
        force_rst   = force_q;
        busy        = state_q != S_IDLE;
        proto_error = asm_error || cmd_bad;
    end

endmodule

// File: tb/tb_serial_command_decoder.sv
// tb_serial_command_decoder: directed and randomized host sessions checked
// against a word-level model of uploads, downloads and reset control.
module tb_serial_command_decoder;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_error, tx_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, force_rst, busy, proto_error;

    int errors = 0;
    int checks = 0;
    int perr_cnt = 0;
    int tx_bad = 0;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [logic [31:0]];
    logic [63:0] wr_q [$];
    logic [7:0]  tx_q [$];
    logic [31:0] up_data [$];

    serial_command_decoder #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_error    (rx_error),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_ready    (tx_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .force_rst   (force_rst),
        .busy        (busy),
        .proto_error (proto_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[11:2]];
    end

    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
        if (tx_start) begin
            tx_q.push_back(tx_data);
            if (!tx_ready) tx_bad++;
        end
        if (proto_error) perr_cnt++;
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk);
                #1 tx_ready = 1'b0;
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick($urandom_range(0, 3));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        tick(2);
        while (busy && n < 5000) begin
            tick(1);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_upload(input logic [31:0] s_raw, input logic [31:0] e_raw, input string tag);
        logic [31:0] s, e, got;
        int base, n;
        s = s_raw & ~32'd3;
        e = e_raw & ~32'd3;
        n = e > s ? int'((e - s) >> 2) : 0;
        base = wr_q.size();
        send_word(32'h0);
        send_word(32'd2);
        send_word(s_raw);
        send_word(e_raw);
        for (int i = 0; i < up_data.size(); i++) send_word(up_data[i]);
        wait_idle({tag, "_idle"});
        check({tag, "_count"}, 32'(wr_q.size() - base), 32'(n));
        for (int i = 0; i < n && base + i < wr_q.size(); i++) begin
            got = wr_q[base + i][63:32];
            check({tag, "_addr"}, got, s + 32'(4 * i));
            got = wr_q[base + i][31:0];
            check({tag, "_data"}, got, up_data[i]);
            ref_mem[s + 32'(4 * i)] = up_data[i];
        end
    endtask

    task automatic do_download(input logic [31:0] s_raw, input logic [31:0] e_raw, input string tag);
        logic [7:0] exp_q [$];
        logic [31:0] s, e, w;
        int base, bad0;
        s = s_raw & ~32'd3;
        e = e_raw & ~32'd3;
        for (logic [31:0] a = s; a < e; a += 4) begin
            w = ref_mem[a];
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
        end
        base = tx_q.size();
        bad0 = tx_bad;
        send_word(32'h0);
        send_word(32'd3);
        send_word(s_raw);
        send_word(e_raw);
        wait_idle({tag, "_idle"});
        check({tag, "_count"}, 32'(tx_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < tx_q.size(); i++)
            check({tag, "_byte"}, 32'(tx_q[base + i]), 32'(exp_q[i]));
        check({tag, "_ready"}, 32'(tx_bad - bad0), 32'd0);
    endtask

    initial begin
        logic [31:0] s_raw, e_raw;
        int n, p0, t0;
        rst = 1'b1;
        rx_data = '0;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_force", 32'(force_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_re", 32'(mem_re), 32'd0);
        check("rst_tx", 32'(tx_start), 32'd0);
        check("rst_perr", 32'(proto_error), 32'd0);

        send_word(32'h0);
        send_word(32'd5);
        tick(2);
        check("rstctl_low", 32'(force_rst), 32'd0);
        check("rstctl_low_busy", 32'(busy), 32'd0);
        send_word(32'h0);
        send_word(32'd4);
        tick(2);
        check("rstctl_high", 32'(force_rst), 32'd1);

        p0 = perr_cnt;
        n = wr_q.size();
        send_word(32'h0);
        tick(2);
        check("nop_cmd_busy", 32'(busy), 32'd1);
        send_word(32'd0);
        tick(2);
        check("nop_busy", 32'(busy), 32'd0);
        check("nop_force", 32'(force_rst), 32'd1);
        check("nop_perr", 32'(perr_cnt - p0), 32'd0);
        check("nop_we", 32'(wr_q.size() - n), 32'd0);

        up_data = '{32'h12345678, 32'hAABBAABB, 32'hCCCCCCCC, 32'h11112222,
                    32'h12345678, 32'hAABBAABB, 32'hCCCCCCCC, 32'h11112222};
        do_upload(32'h400, 32'h420, "up_fixed");
        do_download(32'h400, 32'h420, "dn_fixed");

        for (int r = 0; r < 3; r++) begin
            s_raw = 32'h800 + 32'($urandom_range(0, 1023));
            n = $urandom_range(1, 6);
            e_raw = (s_raw & ~32'd3) + 32'(4 * n) + 32'($urandom_range(0, 3));
            up_data.delete();
            for (int i = 0; i < n; i++) up_data.push_back(i == 1 ? 32'h0 : $urandom);
            do_upload(s_raw, e_raw, "up_rand");
            do_download(s_raw, e_raw, "dn_rand");
        end

        up_data = '{32'h55};
        n = wr_q.size();
        send_word(32'h0);
        send_word(32'd2);
        send_word(32'h420);
        send_word(32'h400);
        tick(2);
        check("inv_busy", 32'(busy), 32'd0);
        send_word(32'h55);
        wait_idle("inv_idle");
        check("inv_we", 32'(wr_q.size() - n), 32'd0);
        up_data.delete();
        do_download(32'h400, 32'h400, "dn_empty");

        p0 = perr_cnt;
        send_word(32'h0);
        send_word(32'd7);
        tick(2);
        check("bad_perr", 32'(perr_cnt - p0), 32'd1);
        check("bad_busy", 32'(busy), 32'd0);
        check("bad_force", 32'(force_rst), 32'd1);

        p0 = perr_cnt;
        send_byte(8'hAB);
        send_byte(8'hCD);
        tick(TO + 5);
        check("timeout_perr", 32'(perr_cnt - p0), 32'd1);
        send_word(32'h0);
        send_word(32'd5);
        tick(2);
        check("timeout_clean", 32'(force_rst), 32'd0);

        p0 = perr_cnt;
        send_byte(8'h11);
        rx_error = 1'b1;
        tick(1);
        rx_error = 1'b0;
        tick(2);
        check("rxerr_perr", 32'(perr_cnt - p0), 32'd1);
        send_word(32'h0);
        send_word(32'd4);
        tick(2);
        check("rxerr_clean", 32'(force_rst), 32'd1);
        send_word(32'h0);
        send_word(32'd5);
        tick(2);
        check("pre_abort_force", 32'(force_rst), 32'd0);

        t0 = tx_q.size();
        send_word(32'h0);
        send_word(32'd3);
        send_word(32'h400);
        send_word(32'h420);
        n = 0;
        while (tx_q.size() - t0 < 6 && n < 2000) begin
            tick(1);
            n++;
        end
        check("abort_progress", 32'(tx_q.size() - t0 >= 6), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_tx", 32'(tx_start), 32'd0);
        check("abort_force", 32'(force_rst), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        t0 = tx_q.size();
        tick(4);
        rst = 1'b0;
        tick(40);
        check("abort_quiet", 32'(tx_q.size() - t0), 32'd0);
        check("abort_force_hold", 32'(force_rst), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
